// File: rtl/data_mem_arbiter_pkg.sv
// Shared types for the data_mem arbiter: request payload struct, arbiter
// state encoding and request classification helpers.
package data_mem_arbiter_pkg;

    localparam int RS_ID_W      = 5;
    localparam int RESULT_REG_W = 5;
    localparam int ADDR_W       = 32;
    localparam int BE_W         = 4;
    localparam int DATA_W       = 32;

    typedef struct packed {
        logic [0:RS_ID_W-1]      rs_id;
        logic [0:RESULT_REG_W-1] result_reg;
        logic [0:ADDR_W-1]       address;
        logic [0:BE_W-1]         write_en;
        logic [0:DATA_W-1]       write_data;
        logic [0:BE_W-1]         read_en;
    } mem_req_t;

    typedef enum logic {
        ARB_FREE,
        ARB_HOLD
    } arb_state_t;

    // Any read byte enable makes the request a read, even if write enables are also set.
    function automatic logic is_read(input mem_req_t r);
        return |r.read_en;
    endfunction

    function automatic logic is_write(input mem_req_t r);
        return (|r.write_en) & ~(|r.read_en);
    endfunction

endpackage

// File: rtl/data_mem_arbiter_if.sv
// Bus bundle between the load/store reservation stations, the arbiter and
// data_mem. The slave modport is the arbiter's view; master is the
// environment (requesters plus data_mem).
interface data_mem_arbiter_if
    import data_mem_arbiter_pkg::*;
#(
    parameter int NUM_REQ     = 2,
    parameter int RS_ID_WIDTH = RS_ID_W
);
    logic [NUM_REQ-1:0]      req_valid;
    logic [NUM_REQ-1:0]      req_ready;
    logic [0:RS_ID_WIDTH-1]  req_rs_id      [NUM_REQ];
    logic [0:RESULT_REG_W-1] req_result_reg [NUM_REQ];
    logic [0:ADDR_W-1]       req_address    [NUM_REQ];
    logic [0:BE_W-1]         req_write_en   [NUM_REQ];
    logic [0:DATA_W-1]       req_write_data [NUM_REQ];
    logic [0:BE_W-1]         req_read_en    [NUM_REQ];

    logic                    mem_in_valid;
    logic                    mem_in_ready;
    logic [0:RS_ID_WIDTH-1]  mem_rs_id;
    logic [0:RESULT_REG_W-1] mem_result_reg;
    logic [0:ADDR_W-1]       mem_address;
    logic [0:BE_W-1]         mem_write_en;
    logic [0:DATA_W-1]       mem_write_data;
    logic [0:BE_W-1]         mem_read_en;

    logic                    mem_out_valid;
    logic                    mem_out_ready;
    logic [0:RS_ID_WIDTH-1]  mem_out_rs_id;
    logic [0:RESULT_REG_W-1] mem_out_result_reg;
    logic [0:DATA_W-1]       mem_read_data;

    logic [NUM_REQ-1:0]      resp_valid;
    logic [NUM_REQ-1:0]      resp_ready;
    logic [0:RS_ID_WIDTH-1]  resp_rs_id;
    logic [0:RESULT_REG_W-1] resp_result_reg;
    logic [0:DATA_W-1]       resp_read_data;

    logic                    protocol_error;

    modport slave (
        input  req_valid, req_rs_id, req_result_reg, req_address,
               req_write_en, req_write_data, req_read_en,
               mem_in_ready,
               mem_out_valid, mem_out_rs_id, mem_out_result_reg, mem_read_data,
               resp_ready,
        output req_ready,
               mem_in_valid, mem_rs_id, mem_result_reg, mem_address,
               mem_write_en, mem_write_data, mem_read_en,
               mem_out_ready,
               resp_valid, resp_rs_id, resp_result_reg, resp_read_data,
               protocol_error
    );

    modport master (
        output req_valid, req_rs_id, req_result_reg, req_address,
               req_write_en, req_write_data, req_read_en,
               mem_in_ready,
               mem_out_valid, mem_out_rs_id, mem_out_result_reg, mem_read_data,
               resp_ready,
        input  req_ready,
               mem_in_valid, mem_rs_id, mem_result_reg, mem_address,
               mem_write_en, mem_write_data, mem_read_en,
               mem_out_ready,
               resp_valid, resp_rs_id, resp_result_reg, resp_read_data,
               protocol_error
    );

endinterface

// File: rtl/data_mem_arbiter_rr_arbiter.sv
// Round-robin grant selection with a grant lock (the rr_arbiter of the
// data_mem arbiter). The search starts at ptr; once a grant is stalled by
// the downstream port it is frozen until the handshake completes.
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   ARB_FREE | no stalled grant; grant follows the round-robin search
//   ARB_HOLD | grant hold_q was offered but not accepted; grant is frozen
module data_mem_arbiter_rr_arbiter
    import data_mem_arbiter_pkg::*;
#(
    parameter int N     = 2,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     eligible,
    input  logic             lock,
    output logic [IDX_W-1:0] grant,
    output logic             grant_valid
);

    arb_state_t       state_q, state_d;
    logic [IDX_W-1:0] hold_q, hold_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [IDX_W-1:0] rr_idx;
    logic             rr_found;

    function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] g);
        return (int'(g) >= N - 1) ? '0 : g + IDX_W'(1);
    endfunction

    // State, frozen grant and round-robin pointer registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ARB_FREE;
            hold_q  <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            ptr_q   <= ptr_d;
        end
    end

    // First eligible requester at or after ptr; scanning downwards lets the nearest one win.
    always_comb begin
        rr_idx   = ptr_q;
        rr_found = 1'b0;
        for (int k = N - 1; k >= 0; k--) begin
            int cand;
            cand = int'(ptr_q) + k;
            if (cand >= N) cand = cand - N;
            if (eligible[IDX_W'(cand)]) begin
                rr_idx   = IDX_W'(cand);
                rr_found = 1'b1;
            end
        end
    end

    // Next-state and grant outputs; the pointer moves past the winner on each handshake.
    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        ptr_d       = ptr_q;
        grant       = rr_idx;
        grant_valid = rr_found;
        case (state_q)
            ARB_FREE: begin
                if (rr_found) begin
                    if (lock) begin
                        state_d = ARB_HOLD;
                        hold_d  = rr_idx;
                    end else begin
                        ptr_d = wrap_inc(rr_idx);
                    end
                end
            end
            ARB_HOLD: begin
                grant       = hold_q;
                grant_valid = 1'b1;
                if (!lock) begin
                    state_d = ARB_FREE;
                    ptr_d   = wrap_inc(hold_q);
                end
            end
            default: state_d = ARB_FREE;
        endcase
    end

endmodule

// File: rtl/data_mem_arbiter.sv
// Shares the single data_mem port between NUM_REQ load/store requesters.
// Requests are arbitrated round-robin with zero added latency; read
// responses are routed back in issue order through a small order FIFO
// holding the requester index of every accepted read.
// RS_ID_WIDTH must match the package RS_ID_W used by mem_req_t.
module data_mem_arbiter
    import data_mem_arbiter_pkg::*;
#(
    parameter int NUM_REQ         = 2,
    parameter int RS_ID_WIDTH     = RS_ID_W,
    parameter int MAX_OUTSTANDING = 4
)
(
    input logic               clk,
    input logic               rst,
    data_mem_arbiter_if.slave bus
);

    localparam int IDX_W   = $clog2(NUM_REQ);
    localparam int FIFO_AW = $clog2(MAX_OUTSTANDING);
    localparam int PTR_W   = FIFO_AW + 1;
    // Pointers that differ only in the wrap bit mean the FIFO is full.
    localparam logic [PTR_W-1:0] FULL_XOR = PTR_W'(1) << FIFO_AW;

    mem_req_t         req [NUM_REQ];
    mem_req_t         sel;
    logic [NUM_REQ-1:0] eligible;
    logic [IDX_W-1:0] grant;
    logic             grant_valid;
    logic             handshake;
    logic             push;
    logic             pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [IDX_W-1:0] order_q [MAX_OUTSTANDING];
    logic [IDX_W-1:0] head;
    logic             protocol_error_q;

    // Pack each requester's payload and decide who may compete this cycle.
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            req[i].rs_id      = bus.req_rs_id[i];
            req[i].result_reg = bus.req_result_reg[i];
            req[i].address    = bus.req_address[i];
            req[i].write_en   = bus.req_write_en[i];
            req[i].write_data = bus.req_write_data[i];
            req[i].read_en    = bus.req_read_en[i];
            eligible[i] = bus.req_valid[i] &
                          (is_write(req[i]) | (is_read(req[i]) & ~fifo_full));
        end
    end

    data_mem_arbiter_rr_arbiter #(.N(NUM_REQ)) u_rr_arbiter (
        .clk         (clk),
        .rst         (rst),
        .eligible    (eligible),
        .lock        (~bus.mem_in_ready),
        .grant       (grant),
        .grant_valid (grant_valid)
    );

    assign sel        = req[grant];
    assign handshake  = grant_valid & bus.mem_in_ready & ~rst;
    assign push       = handshake & is_read(sel);
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = ((wr_ptr ^ rd_ptr) == FULL_XOR);
    assign head       = order_q[rd_ptr[FIFO_AW-1:0]];
    assign pop        = bus.mem_out_valid & bus.mem_out_ready & ~fifo_empty;

    // Request mux and response routing; an empty FIFO drains stray responses.
    always_comb begin
        bus.mem_in_valid   = grant_valid & ~rst;
        bus.mem_rs_id      = sel.rs_id;
        bus.mem_result_reg = sel.result_reg;
        bus.mem_address    = sel.address;
        bus.mem_write_en   = sel.write_en;
        bus.mem_write_data = sel.write_data;
        bus.mem_read_en    = sel.read_en;

        bus.req_ready = '0;
        if (handshake) bus.req_ready[grant] = 1'b1;

        bus.resp_valid = '0;
        if (~rst & ~fifo_empty & bus.mem_out_valid) bus.resp_valid[head] = 1'b1;

        bus.mem_out_ready = 1'b0;
        if (~rst) bus.mem_out_ready = fifo_empty ? 1'b1 : bus.resp_ready[head];

        bus.resp_rs_id      = bus.mem_out_rs_id;
        bus.resp_result_reg = bus.mem_out_result_reg;
        bus.resp_read_data  = bus.mem_read_data;
        bus.protocol_error  = protocol_error_q;
    end

    // Order FIFO pointers and the sticky protocol error flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr           <= '0;
            rd_ptr           <= '0;
            protocol_error_q <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            if (bus.mem_out_valid & fifo_empty) protocol_error_q <= 1'b1;
        end
    end

    // Order FIFO storage; contents are only meaningful between the pointers.
    always_ff @(posedge clk) begin
        if (push) order_q[wr_ptr[FIFO_AW-1:0]] <= grant;
    end

endmodule
